mem_copy_master: RTL and testbench

Bus initiator that drives the Memory_System port (Address_i, Write_Data, write_enable_i, Instruction_o) from the requesting side. On a start pulse it copies a block of 32-bit words from a source region to a destination region, typically ROM (0x00400000 window) to data RAM (0x10010000 window). It replaces hand-written testbench stimulus with a synthesizable engine that loads RAM at boot.

---
 rtl/mem_copy_pkg.sv | 17 +
 rtl/copy_addr_gen.sv | 45 ++++
 rtl/mem_copy_master.sv | 139 +++++++++++++
 tb/tb_mem_copy_master.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_copy_pkg.sv
// Shared types and constants for the boot-time memory copy engine.
// Holds the FSM encoding and the ROM/RAM window bases.
package mem_copy_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WAIT,
        ST_WR,
        ST_DONE
    } state_e;

    localparam int unsigned WORD_BYTES = 4;
    localparam logic [31:0] ROM_BASE = 32'h0040_0000;
    localparam logic [31:0] RAM_BASE = 32'h1001_0000;

endpackage

// File: rtl/copy_addr_gen.sv
// Word counter plus source/destination address walkers for the copy engine.
// Both addresses advance one word per step; last flags the final word.
module copy_addr_gen
    import mem_copy_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 7
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    input  logic                  load,
    input  logic                  step,
    input  logic [DATA_WIDTH-1:0] src_base,
    input  logic [DATA_WIDTH-1:0] dst_base,
    input  logic [LEN_WIDTH-1:0]  len,
    output logic [DATA_WIDTH-1:0] src_addr,
    output logic [DATA_WIDTH-1:0] dst_addr,
    output logic                  last
);

    logic [LEN_WIDTH-1:0] cnt_q;
    logic [LEN_WIDTH-1:0] len_q;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            cnt_q    <= '0;
            len_q    <= '0;
            src_addr <= '0;
            dst_addr <= '0;
        end else if (load) begin
            cnt_q    <= '0;
            len_q    <= len;
            src_addr <= src_base;
            dst_addr <= dst_base;
        end else if (step) begin
            cnt_q    <= cnt_q + LEN_WIDTH'(1);
            src_addr <= src_addr + DATA_WIDTH'(WORD_BYTES);
            dst_addr <= dst_addr + DATA_WIDTH'(WORD_BYTES);
        end
    end

    // Only consulted while copying, where len_q is at least one.
    assign last = (cnt_q == len_q - LEN_WIDTH'(1));

endmodule

// File: rtl/mem_copy_master.sv
// Bus initiator that copies a block of words between memory regions.
// Every bus-side output is a register fed from the next-state logic.
module mem_copy_master
    import mem_copy_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int MEMORY_DEPTH = 64,
    parameter int READ_LATENCY = 1,
    localparam int LEN_WIDTH   = $clog2(MEMORY_DEPTH) + 1
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    input  logic                  start_i,
    input  logic [DATA_WIDTH-1:0] src_addr_i,
    input  logic [DATA_WIDTH-1:0] dst_addr_i,
    input  logic [LEN_WIDTH-1:0]  len_i,
    input  logic [DATA_WIDTH-1:0] Read_Data_i,
    output logic [DATA_WIDTH-1:0] Address_o,
    output logic [DATA_WIDTH-1:0] Write_Data_o,
    output logic                  write_enable_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  error_o
);

    state_e state_q, state_d;
    logic [1:0] wait_q, wait_d;

    logic [DATA_WIDTH-1:0] addr_d;
    logic [DATA_WIDTH-1:0] wdata_d;
    logic we_d, busy_d, done_d, error_d;

    logic load, step, last_word;
    logic [DATA_WIDTH-1:0] cur_src, cur_dst;
    logic misaligned;

    assign misaligned = (src_addr_i[1:0] != 2'b00) ||
                        (dst_addr_i[1:0] != 2'b00);

    copy_addr_gen #(
        .DATA_WIDTH(DATA_WIDTH),
        .LEN_WIDTH (LEN_WIDTH)
    ) u_addr_gen (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .load     (load),
        .step     (step),
        .src_base (src_addr_i),
        .dst_base (dst_addr_i),
        .len      (len_i),
        .src_addr (cur_src),
        .dst_addr (cur_dst),
        .last     (last_word)
    );

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        addr_d  = Address_o;
        wdata_d = Write_Data_o;
        we_d    = 1'b0;
        error_d = error_o;
        load    = 1'b0;
        step    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    load    = 1'b1;
                    error_d = 1'b0;
                    if (misaligned) begin
                        error_d = 1'b1;
                        state_d = ST_DONE;
                    end else if (len_i == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RD;
                        addr_d  = src_addr_i;
                    end
                end
            end
            ST_RD: begin
                wait_d  = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Read data is valid during the final wait cycle only.
                if (wait_q == 2'(READ_LATENCY - 1)) begin
                    state_d = ST_WR;
                    addr_d  = cur_dst;
                    wdata_d = Read_Data_i;
                    we_d    = 1'b1;
                end else begin
                    wait_d = wait_q + 2'd1;
                end
            end
            ST_WR: begin
                step = 1'b1;
                if (last_word) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RD;
                    addr_d  = cur_src + DATA_WIDTH'(WORD_BYTES);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d == ST_RD) || (state_d == ST_WAIT) ||
                 (state_d == ST_WR);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q        <= ST_IDLE;
            wait_q         <= '0;
            Address_o      <= '0;
            Write_Data_o   <= '0;
            write_enable_o <= 1'b0;
            busy_o         <= 1'b0;
            done_o         <= 1'b0;
            error_o        <= 1'b0;
        end else begin
            state_q        <= state_d;
            wait_q         <= wait_d;
            Address_o      <= addr_d;
            Write_Data_o   <= wdata_d;
            write_enable_o <= we_d;
            busy_o         <= busy_d;
            done_o         <= done_d;
            error_o        <= error_d;
        end
    end

endmodule

// File: tb/tb_mem_copy_master.sv
// Directed bench: three engines at read latency 1..3 over ROM/RAM models.
// Expected writes are queued at stimulus time and matched as they appear.
module tb_mem_copy_master;
    import mem_copy_pkg::*;

    typedef struct packed {
        logic [1:0]  g;
        logic [31:0] a;
        logic [31:0] d;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic ram_clr;
    logic [2:0] start;
    logic [2:0][31:0] src, dst, addr, wdata, rdata;
    logic [2:0][6:0] len;
    logic [2:0] we, busy, done, err;

    logic [31:0] rom [3][64];
    logic [31:0] ram [3][64];
    logic [31:0] pipe [3][3];

    int checks = 0;
    int failures = 0;
    int busy_cnt [3] = '{0, 0, 0};
    int wr_cnt [3] = '{0, 0, 0};
    exp_t sbq [$];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mem_copy_master #(
            .DATA_WIDTH  (32),
            .MEMORY_DEPTH(64),
            .READ_LATENCY(g + 1)
        ) u_dut (
            .clk_i         (clk),
            .reset_n_i     (rst_n),
            .start_i       (start[g]),
            .src_addr_i    (src[g]),
            .dst_addr_i    (dst[g]),
            .len_i         (len[g]),
            .Read_Data_i   (rdata[g]),
            .Address_o     (addr[g]),
            .Write_Data_o  (wdata[g]),
            .write_enable_o(we[g]),
            .busy_o        (busy[g]),
            .done_o        (done[g]),
            .error_o       (err[g])
        );
        assign rdata[g] = pipe[g][g];
    end

    function automatic logic [31:0] mem_rd(int g, logic [31:0] a);
        logic [31:0] ro;
        logic [31:0] ra;
        ro = a - ROM_BASE;
        ra = a - RAM_BASE;
        if (ro < 32'd256) return rom[g][ro[7:2]];
        if (ra < 32'd256) return ram[g][ra[7:2]];
        return 32'hDEAD_BEEF;
    endfunction

    always @(posedge clk) begin
        logic [31:0] off;
        for (int g = 0; g < 3; g++) begin
            off = addr[g] - RAM_BASE;
            if (ram_clr) begin
                for (int k = 0; k < 64; k++) ram[g][k] <= '0;
            end else if (we[g] === 1'b1 && off < 32'd256) begin
                ram[g][off[7:2]] <= wdata[g];
            end
            pipe[g][0] <= mem_rd(g, addr[g]);
            pipe[g][1] <= pipe[g][0];
            pipe[g][2] <= pipe[g][1];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        for (int g = 0; g < 3; g++) begin
            if (busy[g] === 1'b1) busy_cnt[g]++;
            if (we[g] === 1'b1) begin
                wr_cnt[g]++;
                checks++;
                assert (sbq.size() != 0) else begin
                    failures++;
                    $error("FAIL unexpected_write observed=%h expected=none",
                           addr[g]);
                end
                if (sbq.size() != 0) begin
                    e = sbq.pop_front();
                    chk("wr_inst", 32'(g), 32'(e.g));
                    chk("wr_addr", addr[g], e.a);
                    chk("wr_data", wdata[g], e.d);
                end
            end
        end
    end

    task automatic start_copy(input int g, input logic [31:0] s,
                              input logic [31:0] d, input int n);
        @(negedge clk);
        src[g] = s;
        dst[g] = d;
        len[g] = 7'(n);
        start[g] = 1'b1;
        @(posedge clk);
        #1 start[g] = 1'b0;
    endtask

    task automatic wait_done(input int g, input int c0, input int limit,
                             output int cyc);
        cyc = c0;
        while (done[g] !== 1'b1 && cyc < limit) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("done_seen", 32'(done[g]), 32'd1);
    endtask

    task automatic push_exp(input int g, input logic [31:0] s,
                            input logic [31:0] d, input int n);
        logic [31:0] so;
        exp_t e;
        so = (s - ROM_BASE) >> 2;
        for (int k = 0; k < n; k++) begin
            e.g = 2'(g);
            e.a = d + 32'(4 * k);
            e.d = rom[g][int'(so) + k];
            sbq.push_back(e);
        end
    endtask

    task automatic run_copy(input int g, input logic [31:0] s,
                            input logic [31:0] d, input int n,
                            input int exp_wr, input int exp_cyc,
                            input logic exp_err);
        int b0, w0, cyc;
        push_exp(g, s, d, exp_wr);
        b0 = busy_cnt[g];
        w0 = wr_cnt[g];
        start_copy(g, s, d, n);
        wait_done(g, 1, 80, cyc);
        chk("done_cycle", 32'(cyc), 32'(exp_cyc));
        chk("error_flag", 32'(err[g]), 32'(exp_err));
        @(posedge clk);
        #1;
        chk("done_pulse_low", 32'(done[g]), 32'd0);
        chk("busy_cycles", 32'(busy_cnt[g] - b0), 32'(exp_cyc - 1));
        chk("write_count", 32'(wr_cnt[g] - w0), 32'(exp_wr));
        chk("sb_empty", 32'(sbq.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, cyc;
        rst_n = 1'b0;
        ram_clr = 1'b1;
        start = '0;
        src = '0;
        dst = '0;
        len = '0;
        for (int g = 0; g < 3; g++)
            for (int k = 0; k < 64; k++)
                rom[g][k] = (k < 8) ? 32'h1111_1111 * 32'(k + 1)
                                    : 32'hA500_0000 | 32'(k);

        // Reset held with start asserted: everything stays quiet.
        start[0] = 1'b1;
        src[0] = ROM_BASE;
        dst[0] = RAM_BASE;
        len[0] = 7'd4;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("rst_addr", addr[0], 32'd0);
            chk("rst_wdata", wdata[0], 32'd0);
            chk("rst_we", 32'(we[0]), 32'd0);
            chk("rst_busy", 32'(busy[0]), 32'd0);
            chk("rst_done", 32'(done[0]), 32'd0);
            chk("rst_err", 32'(err[0]), 32'd0);
        end
        @(negedge clk);
        start[0] = 1'b0;
        ram_clr = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_no_write", 32'(wr_cnt[0]), 32'd0);

        // Nominal 4-word ROM to RAM copy.
        run_copy(0, ROM_BASE, RAM_BASE, 4, 4, 13, 1'b0);
        for (int k = 0; k < 4; k++)
            chk("nom_ram", ram[0][k], 32'h1111_1111 * 32'(k + 1));

        // Misaligned source flags error, then error persists while idle.
        run_copy(0, ROM_BASE + 32'd2, RAM_BASE, 4, 0, 1, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk("err_held", 32'(err[0]), 32'd1);
        run_copy(0, ROM_BASE, RAM_BASE + 32'd1, 4, 0, 1, 1'b1);

        // Zero-length request also clears the prior error.
        run_copy(0, ROM_BASE, RAM_BASE, 0, 0, 1, 1'b0);

        // Second start mid-copy is dropped.
        push_exp(0, ROM_BASE, RAM_BASE + 32'h40, 2);
        w0 = wr_cnt[0];
        start_copy(0, ROM_BASE, RAM_BASE + 32'h40, 2);
        @(posedge clk);
        #1;
        @(negedge clk);
        src[0] = ROM_BASE + 32'h10;
        dst[0] = RAM_BASE + 32'h80;
        len[0] = 7'd5;
        start[0] = 1'b1;
        @(posedge clk);
        #1 start[0] = 1'b0;
        wait_done(0, 3, 80, cyc);
        chk("ign_done_cycle", 32'(cyc), 32'd7);
        repeat (10) @(posedge clk);
        #1;
        chk("ign_busy", 32'(busy[0]), 32'd0);
        chk("ign_writes", 32'(wr_cnt[0] - w0), 32'd2);
        chk("ign_sb_empty", 32'(sbq.size()), 32'd0);
        chk("ign_ram", ram[0][17], 32'h2222_2222);

        // Reset during the wait of word 2 of an 8-word copy.
        @(negedge clk);
        ram_clr = 1'b1;
        @(posedge clk);
        #1 ram_clr = 1'b0;
        push_exp(0, ROM_BASE, RAM_BASE, 2);
        w0 = wr_cnt[0];
        start_copy(0, ROM_BASE, RAM_BASE, 8);
        repeat (7) begin
            @(posedge clk);
            #1;
        end
        chk("abort_wait_addr", addr[0], ROM_BASE + 32'd8);
        chk("abort_wait_busy", 32'(busy[0]), 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("abort_we", 32'(we[0]), 32'd0);
        chk("abort_busy", 32'(busy[0]), 32'd0);
        chk("abort_addr", addr[0], 32'd0);
        chk("abort_done", 32'(done[0]), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        chk("abort_writes", 32'(wr_cnt[0] - w0), 32'd2);
        chk("abort_sb_empty", 32'(sbq.size()), 32'd0);
        chk("abort_ram1", ram[0][1], 32'h2222_2222);
        chk("abort_ram2", ram[0][2], 32'd0);

        // Fresh full copy after the abort.
        run_copy(0, ROM_BASE, RAM_BASE, 8, 8, 25, 1'b0);
        for (int k = 0; k < 8; k++)
            chk("restart_ram", ram[0][k], 32'h1111_1111 * 32'(k + 1));

        // Latency sweep on the slower engines.
        run_copy(1, ROM_BASE, RAM_BASE, 4, 4, 17, 1'b0);
        run_copy(2, ROM_BASE, RAM_BASE, 4, 4, 21, 1'b0);
        for (int k = 0; k < 4; k++) begin
            chk("lat2_ram", ram[1][k], 32'h1111_1111 * 32'(k + 1));
            chk("lat3_ram", ram[2][k], 32'h1111_1111 * 32'(k + 1));
        end
        chk("lat2_ram_beyond", ram[1][4], 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
